// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg: shared irq edge-mode encoding, glitch filter constant and edge-match helper
package gpio_pad_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } irq_mode_t;

   // filter counter value at which the third consecutive differing sample commits
   localparam logic [1:0] FILT_LAST = 2'd2;

   function automatic logic edge_hit(irq_mode_t m, logic r, logic f);
      return ((m == MODE_RISE || m == MODE_BOTH) && r) || ((m == MODE_FALL || m == MODE_BOTH) && f);
   endfunction

endpackage

// File: rtl/gpio_pad_chan.sv
// gpio_pad_chan: one pad channel (tristate, synchronizer, optional GPIO_PAD_BANK_GLITCH_FILTER_EN filter, edge detect, pending flag)
import gpio_pad_pkg::*;

module gpio_pad_chan #(
   parameter int SYNC_STAGES = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   inout  wire       pad,
   input  logic      dout,
   input  logic      oe,
   input  logic      ie,
   input  irq_mode_t mode,
   input  logic      clr,
   output logic      din,
   output logic      pending
);

   logic                   raw;
   logic                   prev;
   logic [SYNC_STAGES-1:0] sync;

   assign pad = oe ? dout : 1'bz;
   assign raw = ie & pad;

   // shift the gated pad value through the synchronizer chain
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], raw};

`ifdef GPIO_PAD_BANK_GLITCH_FILTER_EN
   logic [1:0] cnt;
   logic       din_q;

   // commit a new level only after three consecutive differing samples
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= '0;
         din_q <= 1'b0;
      end else if (sync[SYNC_STAGES-1] == din_q) begin
         cnt   <= '0;
      end else if (cnt == FILT_LAST) begin
         cnt   <= '0;
         din_q <= sync[SYNC_STAGES-1];
      end else begin
         cnt   <= cnt + 2'd1;
      end

   assign din = din_q;
`else
   assign din = sync[SYNC_STAGES-1];
`endif

   // remember last din and latch matching edges; a set outranks a clear
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         prev    <= 1'b0;
         pending <= 1'b0;
      end else begin
         prev    <= din;
         pending <= (ie && edge_hit(mode, din & ~prev, ~din & prev)) || (pending && !clr);
      end

endmodule

// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank: bank of NPINS independent GPIO pads with edge interrupts (glitch filter under GPIO_PAD_BANK_GLITCH_FILTER_EN)
import gpio_pad_pkg::*;

module gpio_pad_bank #(
   parameter int NPINS       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   inout  wire  [NPINS-1:0]   pad,
   input  logic [NPINS-1:0]   dout,
   input  logic [NPINS-1:0]   oe,
   input  logic [NPINS-1:0]   ie,
   output logic [NPINS-1:0]   din,
   input  logic [2*NPINS-1:0] irq_mode,
   input  logic [NPINS-1:0]   irq_en,
   input  logic [NPINS-1:0]   irq_clr,
   output logic [NPINS-1:0]   irq_pending,
   output logic               irq
);

   genvar i;
   generate
      for (i = 0; i < NPINS; i++) begin : g_chan
         gpio_pad_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad     (pad[i]),
            .dout    (dout[i]),
            .oe      (oe[i]),
            .ie      (ie[i]),
            .mode    (irq_mode_t'(irq_mode[2*i +: 2])),
            .clr     (irq_clr[i]),
            .din     (din[i]),
            .pending (irq_pending[i])
         );
      end
   endgenerate

   assign irq = |(irq_pending & irq_en);

endmodule

// File: tb/tb_gpio_pad_bank.sv
// tb_gpio_pad_bank: directed self-checking bench for gpio_pad_bank
module tb_gpio_pad_bank;

   localparam int NPINS = 8;
   localparam int SYNC  = 2;
`ifdef GPIO_PAD_BANK_GLITCH_FILTER_EN
   localparam int LAT   = SYNC + 3;
`else
   localparam int LAT   = SYNC;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   wire  [NPINS-1:0]  pad;
   logic [NPINS-1:0]  dout, oe, ie, din, irq_en, irq_clr, irq_pending, ext_val;
   logic [2*NPINS-1:0] irq_mode;
   logic              irq;
   int                n_cmp = 0;
   int                n_err = 0;

   always #5 clk = ~clk;

   genvar k;
   generate
      for (k = 0; k < NPINS; k++) begin : g_ext
         assign pad[k] = oe[k] ? 1'bz : ext_val[k];
      end
   endgenerate

   gpio_pad_bank #(.NPINS(NPINS), .SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pad         (pad),
      .dout        (dout),
      .oe          (oe),
      .ie          (ie),
      .din         (din),
      .irq_mode    (irq_mode),
      .irq_en      (irq_en),
      .irq_clr     (irq_clr),
      .irq_pending (irq_pending),
      .irq         (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; dout = '0; oe = '0; ie = '0; irq_mode = '0;
      irq_en = '0; irq_clr = '0; ext_val = '0;
      #2;
      check("rst_din", din, 0);
      check("rst_pend", irq_pending, 0);
      check("rst_irq", irq, 0);
      tick(2);
      rst_n = 1'b1;
      check("rel_irq0", irq, 0);
      tick(1);
      check("rel_irq1", irq, 0);
      // pin3 rise, pin1 both, pin2 off
      ie = 8'hFF; irq_en = 8'h08; irq_mode = 16'h004C;
      tick(3);
      ie = 8'hFD; tick(1); ie = 8'hFF; tick(4);
      check("ie_toggle_low", irq_pending, 0);
      ext_val = 8'h0C;
      tick(LAT - 1);
      check("din_early", din, 8'h00);
      tick(1);
      check("din_lat", din, 8'h0C);
      check("pend_not_yet", irq_pending, 0);
      tick(1);
      check("rise_pend", irq_pending, 8'h08);
      check("irq_on", irq, 1);
      irq_en = 8'h00; #1;
      check("irq_masked", irq, 0);
      check("pend_held", irq_pending, 8'h08);
      irq_en = 8'h08;
      irq_clr = 8'h08; tick(1); irq_clr = 8'h00;
      check("clr_pend", irq_pending, 0);
      // ie 1->0 on a high pad with mode both must not raise pending
      irq_mode = 16'h00C0; ie = 8'hF7;
      tick(LAT + 2);
      check("ie_off_din", din, 8'h04);
      check("ie_off_pend", irq_pending, 0);
      ie = 8'hFF; tick(LAT + 2);
      irq_clr = 8'hFF; tick(1); irq_clr = 8'h00;
      check("reclear", irq_pending, 0);
      // pin5 fall mode, set/clear collision
      irq_mode = 16'h0800; ext_val[5] = 1'b1;
      tick(LAT + 2);
      check("fall_ignores_rise", irq_pending, 0);
      ext_val[5] = 1'b0;
      tick(LAT);
      irq_clr = 8'h20; tick(1); irq_clr = 8'h00;
      check("set_beats_clr", irq_pending, 8'h20);
      tick(2);
      check("pend5_hold", irq_pending, 8'h20);
      irq_clr = 8'h20; tick(1); irq_clr = 8'h00;
      check("clr5", irq_pending, 0);
      // drive/loopback
      irq_mode = '0; oe = 8'h0F; dout = 8'h05; ext_val = 8'hA0; #1;
      check("pad_drive", pad, 8'hA5);
      tick(LAT);
      check("loopback", din, 8'hA5);
      // all pending then async reset mid-stream
      oe = '0; irq_mode = 16'hFFFF; ext_val = '0;
      tick(LAT + 2);
      irq_clr = 8'hFF; tick(1); irq_clr = 8'h00;
      ext_val = 8'hFF;
      tick(LAT + 2);
      check("all_pend", irq_pending, 8'hFF);
      irq_en = 8'hFF; #1;
      check("all_irq", irq, 1);
      rst_n = 1'b0; #1;
      check("arst_pend", irq_pending, 0);
      check("arst_din", din, 0);
      check("arst_irq", irq, 0);
      ext_val = '0;
      tick(2);
      rst_n = 1'b1;
      check("rel2_irq0", irq, 0);
      tick(1);
      check("rel2_irq1", irq, 0);
      tick(LAT + 2);
      check("rel2_pend", irq_pending, 0);
      check("rel2_din", din, 0);
`ifdef GPIO_PAD_BANK_GLITCH_FILTER_EN
      irq_mode = '0;
      ext_val[0] = 1'b1; tick(2); ext_val[0] = 1'b0;
      tick(8);
      check("glitch_blocked", din[0], 0);
      ext_val[0] = 1'b1;
      tick(LAT - 1);
      check("filt_early", din[0], 0);
      tick(1);
      check("filt_pass", din[0], 1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_pad_bank.md
GPIO_PAD_BANK -- requirements
Module: gpio_pad_bank

Interface
REQ-001 SHALL have parameter NPINS, default 8: number of independent pad channels, range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, range 2..4.
REQ-003 SHALL have port clk  input  1: single clock for all sequential logic.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port pad  inout  NPINS: physical pads.
REQ-006 SHALL have port dout  input  NPINS: per-pin output data.
REQ-007 SHALL have port oe  input  NPINS: per-pin output enable, 1 = drive.
REQ-008 SHALL have port ie  input  NPINS: per-pin input enable, 1 = sample.
REQ-009 SHALL have port din  output  NPINS: synchronized (optionally filtered) input value.
REQ-010 SHALL have port irq_mode  input  2*NPINS: per-pin edge mode, 00 off, 01 rise, 10 fall, 11 both.
REQ-011 SHALL have port irq_en  input  NPINS: per-pin interrupt mask, 1 = enabled.
REQ-012 SHALL have port irq_clr  input  NPINS: per-pin single-cycle pending clear.
REQ-013 SHALL have port irq_pending  output  NPINS: latched edge-event flags.
REQ-014 SHALL have port irq  output  1: OR of irq_pending & irq_en.

Function
REQ-015 SHALL drive pad[i] = dout[i] when oe[i]=1, else high-impedance.
REQ-016 SHALL form raw[i] = pad[i] when ie[i]=1, else 0.
REQ-017 SHALL pass raw[i] through SYNC_STAGES flops; din[i] SHALL follow a pad change after exactly SYNC_STAGES rising edges (filter disabled).
REQ-018 SHALL keep a registered copy prev[i] of din[i]; rise = din & ~prev, fall = ~din & prev.
REQ-019 SHALL set irq_pending[i] on the cycle after a rise/fall matching irq_mode[i] while ie[i]=1; mode 00 SHALL never set it.
REQ-020 SHALL clear irq_pending[i] on the cycle after irq_clr[i]=1; a simultaneous set and clear SHALL leave the bit set.
REQ-021 SHALL hold irq_pending independently of irq_en; irq SHALL be combinational from irq_pending & irq_en.
REQ-022 SHALL not generate events when ie[i] toggles while the pad is static low; ie 1->0 with pad high SHALL NOT set pending (gated by REQ-019).
REQ-023 SHALL loop back driven output: oe=1, ie=1 gives din = dout after SYNC_STAGES cycles.
REQ-024 SHALL treat each channel independently; no cross-channel interaction except the irq OR.

Reset
REQ-025 SHALL asynchronously clear synchronizer flops, prev, filter state, din and irq_pending to 0 on rst_n=0, including mid-operation.
REQ-026 SHALL drive irq=0 during reset and the first cycle after release; pads follow oe/dout combinationally at all times.
REQ-027 SHALL NOT report an edge caused by reset release alone with a low pad.

Configuration
REQ-028 SHALL compile a per-pin glitch filter when GPIO_PAD_BANK_GLITCH_FILTER_EN is defined: din[i] updates only after the synchronized value differs from din[i] for 3 consecutive cycles (2-bit counter, reset 0, restart on any reversal).
REQ-029 SHALL, without GPIO_PAD_BANK_GLITCH_FILTER_EN, connect din directly to the last synchronizer stage, with no filter logic present.

Structure
REQ-030 SHALL place the irq_mode encoding (typedef and OFF/RISE/FALL/BOTH constants) and the filter count constant in package gpio_pad_pkg.
REQ-031 SHALL implement one channel (tristate, synchronizer, filter, edge detect, pending) in sub-module gpio_pad_chan, generated NPINS times.

Verification
REQ-032 SHALL check: NPINS=8, pad[3] driven 0->1 externally, ie=FF, mode[3]=01 -> din[3]=1 after 2 cycles, irq_pending=08 one cycle later, irq=1 iff irq_en[3]=1.
REQ-033 SHALL check: mode[5]=10, pad[5] 1->0, irq_clr[5] pulsed the same cycle pending sets -> irq_pending[5] stays 1; next irq_clr pulse clears it to 0.
REQ-034 SHALL check: oe=0x0F, dout=0x05, ie=0xFF -> pad[3:0]=0101, pad[7:4]=Z, din[3:0]=0101 after SYNC_STAGES cycles.
REQ-035 SHALL check: rst_n pulsed low mid-stream with pending=0xFF -> irq_pending=0, din=0, irq=0 immediately, no event on release.
REQ-036 SHALL check: with GPIO_PAD_BANK_GLITCH_FILTER_EN, 2-cycle high glitch on pad[0] -> din[0] stays 0; 4-cycle high -> din[0]=1 after SYNC_STAGES+3 cycles.
